// File: rtl/adder_arbiter.sv
// Two-requester arbiter in front of a shared external 16-bit adder: accept, add for one cycle, hold the result until consumed.
// Optional feature: define ADDER_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module adder_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [15:0] rsp_sum,
  output logic        rsp_cout,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_sum,
  input  logic        add_cout,
  output logic        busy,
  output logic        grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        winner;
  logic        any_valid;
  logic        accept;
  logic        rsp_ack;
  logic [15:0] res_sum;
  logic        res_cout;

  assign any_valid = req0_valid | req1_valid;

`ifdef ADDER_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // On a tie the requester that was not served last wins; a lone valid always wins.
  assign winner = req1_valid & (~req0_valid | ~last_grant);

  always_ff @(posedge clk) begin
    if (reset)       last_grant <= 1'b1;
    else if (accept) last_grant <= winner;
  end
`else
  assign winner = req1_valid & ~req0_valid;
`endif

  // Only the granted requester's consumer can release the result bus.
  assign rsp_ack = grant ? rsp1_ready : rsp0_ready;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid && !reset) begin
          req0_ready = ~winner;
          req1_ready = winner;
          accept     = 1'b1;
          state_nxt  = ADD;
        end
      end
      ADD:     state_nxt = RESP;
      RESP:    if (rsp_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      add_a    <= '0;
      add_b    <= '0;
      grant    <= 1'b0;
      res_sum  <= '0;
      res_cout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        add_a <= winner ? req1_a : req0_a;
        add_b <= winner ? req1_b : req0_b;
        grant <= winner;
      end
      if (state == ADD) begin
        res_sum  <= add_sum;
        res_cout <= add_cout;
      end
    end
  end

  // Response valids are masked by reset so an abandoned transaction never handshakes.
  assign rsp0_valid = (state == RESP) && !grant && !reset;
  assign rsp1_valid = (state == RESP) &&  grant && !reset;
  assign rsp_sum    = res_sum;
  assign rsp_cout   = res_cout;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: vector table plus hand-written corner sequences, with a response scoreboard.
// Build with ADDER_ARB_ROUND_ROBIN_EN defined to check the round-robin grant order.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [15:0] rsp_sum;
  logic        rsp_cout;
  logic [15:0] add_a, add_b;
  logic [15:0] add_sum;
  logic        add_cout;
  logic        busy, grant;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        g;
    logic [15:0] sum;
    logic        cout;
  } exp_t;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        g;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  // External ripple adder model, carry-in fixed at 0.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  adder_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy), .grant(grant)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic g, input logic [15:0] sum, input logic cout);
    exp_t e;
    e.g = g; e.sum = sum; e.cout = cout;
    sb_q.push_back(e);
  endtask

  // Scoreboard: a response handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset && ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))) begin
      check("rsp_onehot", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_requester", {31'd0, rsp1_valid}, {31'd0, e.g});
        check("rsp_sum", {16'd0, rsp_sum}, {16'd0, e.sum});
        check("rsp_cout", {31'd0, rsp_cout}, {31'd0, e.cout});
      end
    end
  end

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  // One accepted request with immediate consumption; checks ready, latency and operand hold.
  task automatic run_vec(input vec_t v);
    logic [15:0] ea, eb;
    ea = v.g ? v.a1 : v.a0;
    eb = v.g ? v.b1 : v.b0;
    @(posedge clk); #1;
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    check("vec_req0_ready", {31'd0, req0_ready}, {31'd0, ~v.g});
    check("vec_req1_ready", {31'd0, req1_ready}, {31'd0, v.g});
    check("vec_idle_busy", {31'd0, busy}, 32'd0);
    push_exp(v.g, v.sum, v.cout);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("vec_add_busy", {31'd0, busy}, 32'd1);
    check("vec_grant", {31'd0, grant}, {31'd0, v.g});
    check("vec_add_a", {16'd0, add_a}, {16'd0, ea});
    check("vec_add_b", {16'd0, add_b}, {16'd0, eb});
    check("vec_add_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    @(posedge clk); #1;
    check("vec_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, v.g ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    check("vec_back_idle", {31'd0, busy}, 32'd0);
    check("vec_hold_a", {16'd0, add_a}, {16'd0, ea});
  endtask

  logic exp_seq[4];
  bit   got;

  initial begin
    reset = 1'b1;
    idle_inputs();

    vecs[0] = '{1'b1, 1'b0, 16'd10,    16'd9,     16'd0,     16'd0,     1'b0, 16'd19,    1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'd0,     16'd0,     16'hFFFF,  16'h0001,  1'b1, 16'h0000,  1'b1};
    vecs[2] = '{1'b1, 1'b0, 16'hFFFF,  16'hFFFF,  16'd0,     16'd0,     1'b0, 16'hFFFE,  1'b1};
    vecs[3] = '{1'b0, 1'b1, 16'd0,     16'd0,     16'd0,     16'd0,     1'b1, 16'h0000,  1'b0};
    vecs[4] = '{1'b1, 1'b1, 16'h1234,  16'h4321,  16'd7,     16'd8,     1'b0, 16'h5555,  1'b0};
`ifdef ADDER_ARB_ROUND_ROBIN_EN
    vecs[5] = '{1'b1, 1'b1, 16'h8000,  16'h8000,  16'h1000,  16'h0234,  1'b1, 16'h1234,  1'b0};
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    vecs[5] = '{1'b1, 1'b1, 16'h8000,  16'h8000,  16'h1000,  16'h0234,  1'b0, 16'h0000,  1'b1};
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    vecs[6] = '{1'b0, 1'b1, 16'd0,     16'd0,     16'h7FFF,  16'h0001,  1'b1, 16'h8000,  1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant", {31'd0, grant}, 32'd0);
    check("rst_add_a", {16'd0, add_a}, 32'd0);
    check("rst_add_b", {16'd0, add_b}, 32'd0);
    check("rst_rsp_sum", {15'd0, rsp_cout, rsp_sum}, 32'd0);
    check("rst_valid_ready", {28'd0, rsp1_valid, rsp0_valid, req1_ready, req0_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Both requesters valid back to back
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 16'd20; req0_b = 16'd9;
    req1_valid = 1'b1; req1_a = 16'd15; req1_b = 16'd9;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          got = 1'b1;
          check("both_grant", {31'd0, req1_ready}, {31'd0, exp_seq[k]});
          check("both_ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
          push_exp(exp_seq[k], exp_seq[k] ? 16'd24 : 16'd29, 1'b0);
        end
      end
      if (!got) check("both_accept_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 10 && sb_q.size() != 0; c++) @(posedge clk);
    check("both_drained", sb_q.size(), 32'd0);

    // Response backpressure; non-granted rsp1_ready must be ignored
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 16'd10; req0_b = 16'd9;
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    @(negedge clk);
    check("bp_accept", {31'd0, req0_ready}, 32'd1);
    push_exp(1'b0, 16'd19, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 16'd1; req1_b = 16'd1;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rsp0_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
      check("bp_sum_stable", {15'd0, rsp_cout, rsp_sum}, 32'd19);
      check("bp_busy", {31'd0, busy}, 32'd1);
      check("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rsp0_ready = 1'b1; req1_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_release_idle", {31'd0, busy}, 32'd0);
    check("bp_release_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("bp_drained", sb_q.size(), 32'd0);

    // Reset in the middle of ADD abandons the transaction
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 16'd10; req0_b = 16'd9;
    @(negedge clk);
    check("rstadd_accept", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("rstadd_in_add", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstadd_busy", {31'd0, busy}, 32'd0);
    check("rstadd_grant", {31'd0, grant}, 32'd0);
    check("rstadd_ops", {add_a, add_b}, 32'd0);
    check("rstadd_result", {15'd0, rsp_cout, rsp_sum}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rstadd_no_rsp", {28'd0, rsp1_valid, rsp0_valid, req1_ready, req0_ready}, 32'd0);
    end
    run_vec(vecs[0]);

    check("final_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
